fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: four-phase instruction fetch front end.
// A 2-bit phase counter divides each instruction cycle into Q1..Q4. At the
// Q4 edge (the instruction boundary) the next word is latched into inst_reg
// and the PC advances. A GOTO replaces the fetched word with a NOP and
// redirects the PC. A skip request from execute replaces the fetched word
// with a NOP.

module fetch_unit #(
    parameter int unsigned PC_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            skip,
    input  logic [7:0]      prog_data,
    output logic [PC_W-1:0] prog_addr,
    output logic [7:0]      inst_reg,
    output logic            clk1,
    output logic            clk2,
    output logic            clk3,
    output logic            clk4
);

    // Phase encodings; PH_Q4 marks the instruction boundary.
    localparam logic [1:0] PH_Q1 = 2'd0;
    localparam logic [1:0] PH_Q2 = 2'd1;
    localparam logic [1:0] PH_Q3 = 2'd2;
    localparam logic [1:0] PH_Q4 = 2'd3;

    localparam logic [7:0] NOP       = 8'h00;
    localparam logic [1:0] GOTO_OP   = 2'b10;
    localparam logic [3:0] STRB_Q1   = 4'b0001;

    logic [1:0]      ph_q, ph_d;
    logic [3:0]      strobe_q, strobe_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            boundary;
    logic            is_goto;
    logic [PC_W-1:0] goto_target;
    logic [PC_W-1:0] pc_inc;

    // Phase advance: step mod 4 while running; strobes track the next phase
    // so they come straight out of flops aligned with ph_q.
    always_comb begin
        ph_d = ph_q;
        if (run) begin
            ph_d = ph_q + 2'd1;
        end
        strobe_d = STRB_Q1 << ph_d;
    end

    // Boundary decode: GOTO beats skip, skip beats a normal fetch.
    always_comb begin
        boundary    = run && (ph_q == PH_Q4);
        is_goto     = (ir_q[7:6] == GOTO_OP);
        goto_target = PC_W'(ir_q[5:0]);
        pc_inc      = pc_q + PC_W'(1);
        pc_d        = pc_q;
        ir_d        = ir_q;
        if (boundary) begin
            if (is_goto) begin
                pc_d = goto_target;
                ir_d = NOP;
            end else if (skip) begin
                pc_d = pc_inc;
                ir_d = NOP;
            end else begin
                pc_d = pc_inc;
                ir_d = prog_data;
            end
        end
    end

    // Phase counter and strobe flops; reset restarts at Q1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q     <= PH_Q1;
            strobe_q <= STRB_Q1;
        end else begin
            ph_q     <= ph_d;
            strobe_q <= strobe_d;
        end
    end

    // Program counter and instruction register; only move at a boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= NOP;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // Output mapping.
    always_comb begin
        prog_addr = pc_q;
        inst_reg  = ir_q;
        clk1      = strobe_q[0];
        clk2      = strobe_q[1];
        clk3      = strobe_q[2];
        clk4      = strobe_q[3];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit with a scoreboard queue.
// Each table row is one instruction cycle (4 edges); expected values for
// every edge are pushed when inputs are driven and popped after the edge.

module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       skip;
    logic [7:0] prog_data;
    logic [5:0] prog_addr;
    logic [7:0] inst_reg;
    logic       clk1, clk2, clk3, clk4;

    logic [7:0] mem [64];

    int n_checks;
    int n_fail;

    logic [5:0] cur_pc;
    logic [7:0] cur_ir;

    typedef struct packed {
        logic       skip_q4;
        logic       skip_q2;
        logic [7:0] ir;
        logic [5:0] pc;
    } row_t;

    typedef struct packed {
        logic [3:0] strb;
        logic [5:0] pc;
        logic [7:0] ir;
    } exp_t;

    exp_t sb[$];
    row_t rows_a [6];
    row_t rows_b [9];
    row_t rows_c [5];

    fetch_unit #(.PC_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .skip      (skip),
        .prog_data (prog_data),
        .prog_addr (prog_addr),
        .inst_reg  (inst_reg),
        .clk1      (clk1),
        .clk2      (clk2),
        .clk3      (clk3),
        .clk4      (clk4)
    );

    assign prog_data = mem[prog_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one edge, push its expectation, then pop and compare after it.
    task automatic edge_check(input logic r, input logic s, input logic rn,
                              input logic [1:0] eph, input logic [5:0] epc,
                              input logic [7:0] eir, input string tag);
        exp_t       e;
        logic [3:0] one;
        logic [3:0] strb;
        one    = 4'b0001;
        run    = r;
        skip   = s;
        rst_n  = rn;
        e.strb = one << eph;
        e.pc   = epc;
        e.ir   = eir;
        sb.push_back(e);
        @(posedge clk);
        #1;
        skip  = 1'b0;
        rst_n = 1'b1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e    = sb.pop_front();
            strb = {clk4, clk3, clk2, clk1};
            chk({tag, " strobes"}, {4'h0, strb}, {4'h0, e.strb});
            chk({tag, " pc"}, {2'b00, prog_addr}, {2'b00, e.pc});
            chk({tag, " ir"}, inst_reg, e.ir);
        end
    endtask

    // One instruction cycle starting at Q1; boundary result comes from the row.
    task automatic run_row(input row_t rw, input string tag);
        logic s;
        for (int e = 0; e < 4; e++) begin
            s = (e == 3) ? rw.skip_q4 : ((e == 1) ? rw.skip_q2 : 1'b0);
            if (e == 3) begin
                edge_check(1'b1, s, 1'b1, 2'd0, rw.pc, rw.ir,
                           $sformatf("%s e%0d", tag, e));
            end else begin
                edge_check(1'b1, s, 1'b1, 2'(e + 1), cur_pc, cur_ir,
                           $sformatf("%s e%0d", tag, e));
            end
        end
        cur_pc = rw.pc;
        cur_ir = rw.ir;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        run      = 1'b0;
        skip     = 1'b0;
        rst_n    = 1'b0;

        // Sequential program, skip ignored at Q2, skip honoured at Q4 on word 3.
        rows_a[0] = '{1'b0, 1'b0, 8'h10, 6'd1};
        rows_a[1] = '{1'b0, 1'b1, 8'h11, 6'd2};
        rows_a[2] = '{1'b0, 1'b0, 8'h12, 6'd3};
        rows_a[3] = '{1'b0, 1'b0, 8'h13, 6'd4};
        rows_a[4] = '{1'b1, 1'b0, 8'h00, 6'd5};
        rows_a[5] = '{1'b0, 1'b0, 8'h15, 6'd6};

        // GOTO at word 2 -> 5; GOTO at word 7 -> 10 together with skip.
        rows_b[0] = '{1'b0, 1'b0, 8'h20, 6'd1};
        rows_b[1] = '{1'b0, 1'b0, 8'h21, 6'd2};
        rows_b[2] = '{1'b0, 1'b0, 8'h85, 6'd3};
        rows_b[3] = '{1'b0, 1'b0, 8'h00, 6'd5};
        rows_b[4] = '{1'b0, 1'b0, 8'h25, 6'd6};
        rows_b[5] = '{1'b0, 1'b0, 8'h26, 6'd7};
        rows_b[6] = '{1'b0, 1'b0, 8'h8A, 6'd8};
        rows_b[7] = '{1'b1, 1'b0, 8'h00, 6'd10};
        rows_b[8] = '{1'b0, 1'b0, 8'h2A, 6'd11};

        // Word 12 is GOTO 62; then run through 63 and wrap to 0.
        rows_c[0] = '{1'b0, 1'b0, 8'hBE, 6'd13};
        rows_c[1] = '{1'b0, 1'b0, 8'h00, 6'd62};
        rows_c[2] = '{1'b0, 1'b0, 8'h5E, 6'd63};
        rows_c[3] = '{1'b0, 1'b0, 8'h5F, 6'd0};
        rows_c[4] = '{1'b0, 1'b0, 8'h20, 6'd1};

        for (int k = 0; k < 64; k++) mem[k] = 8'(8'h10 + k);

        // Reset with run low still resets.
        edge_check(1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 8'h00, "reset run0");
        cur_pc = '0;
        cur_ir = '0;
        for (int i = 0; i < 6; i++) run_row(rows_a[i], $sformatf("seqA r%0d", i));

        for (int k = 0; k < 64; k++) mem[k] = 8'(8'h20 + k);
        mem[2]  = 8'h85;
        mem[7]  = 8'h8A;
        mem[12] = 8'hBE;

        edge_check(1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 8'h00, "reset run1");
        cur_pc = '0;
        cur_ir = '0;
        for (int i = 0; i < 9; i++) run_row(rows_b[i], $sformatf("seqB r%0d", i));

        // Freeze at Q3 for 7 edges, then resume without losing word 11.
        edge_check(1'b1, 1'b0, 1'b1, 2'd1, 6'd11, 8'h2A, "frz q2");
        edge_check(1'b1, 1'b0, 1'b1, 2'd2, 6'd11, 8'h2A, "frz q3");
        for (int i = 0; i < 7; i++) begin
            edge_check(1'b0, 1'b0, 1'b1, 2'd2, 6'd11, 8'h2A, $sformatf("frz hold%0d", i));
        end
        edge_check(1'b1, 1'b0, 1'b1, 2'd3, 6'd11, 8'h2A, "frz resume q4");
        edge_check(1'b1, 1'b0, 1'b1, 2'd0, 6'd12, 8'h2B, "frz boundary");
        cur_pc = 6'd12;
        cur_ir = 8'h2B;
        for (int i = 0; i < 5; i++) run_row(rows_c[i], $sformatf("wrap r%0d", i));

        // Reset mid-instruction at Q3, then first boundary loads word 0.
        edge_check(1'b1, 1'b0, 1'b1, 2'd1, 6'd1, 8'h20, "mid q2");
        edge_check(1'b1, 1'b0, 1'b1, 2'd2, 6'd1, 8'h20, "mid q3");
        edge_check(1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 8'h00, "mid reset");
        cur_pc = '0;
        cur_ir = '0;
        run_row('{1'b0, 1'b0, 8'h20, 6'd1}, "post reset r0");
        run_row('{1'b0, 1'b0, 8'h21, 6'd2}, "post reset r1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
